// File: rtl/ofm_dma_pkg.sv
// Shared constants for the OFM write DMA: AXI field encodings and FSM state codes.
package ofm_dma_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int unsigned BOUNDARY_4K = 4096;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_RESP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/ofm_axi_skid.sv
// Two-entry valid/ready register slice: output register plus one skid entry, so
// in_ready_o and all outputs come straight from flops.
module ofm_axi_skid #(
  parameter int W = 65
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         out_vld_q;
  logic         skid_vld_q;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         in_fire;
  logic         out_load;

  assign in_ready_o  = !skid_vld_q;
  assign in_fire     = in_valid_i && !skid_vld_q;
  assign out_load    = !out_vld_q || out_ready_i;
  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_q;

  // A beat only lands in the skid entry when the output register is stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (out_load) begin
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else begin
        out_vld_q <= in_fire;
        if (in_fire) out_q <= in_data_i;
      end
    end else if (in_fire) begin
      skid_q     <= in_data_i;
      skid_vld_q <= 1'b1;
    end
  end

endmodule

// File: rtl/ofm_axi_wr_master.sv
// AXI4 write master draining the OFM beat stream to DDR as 4 KB-safe INCR bursts.
// Optional OFM_WR_BRESP_CHECK_EN adds the sticky ofm_wr_err output for non-OKAY BRESP.
module ofm_axi_wr_master
  import ofm_dma_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ap_start,
  input  logic [ADDR_W-1:0]   ofm_base_addr,
  input  logic [31:0]         ofm_transferbyte,
  input  logic                ofm_bram_valid,
  input  logic [DATA_W-1:0]   ofm_bram_data,
  output logic                ofm_axi_ready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic                busy,
  output logic                ap_done,
`ifdef OFM_WR_BRESP_CHECK_EN
  output logic                ofm_wr_err,
`endif
  output logic [2:0]          dbg_state
);

  // Handshake rule on every channel: a transfer happens on a posedge where valid
  // and ready are both high; once valid is up its payload holds until that edge.

  logic [2:0]        state_q, state_d;
  logic              start_s1_q, start_s2_q, start_edge;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [28:0]       beats_left_q, beats_left_d;
  logic [8:0]        blen_q, blen_d, blen_c;
  logic [8:0]        acc_q, acc_d;
  logic [9:0]        room_beats;
  logic [28:0]       lim_a, lim_b;
  logic              up_fire, b_fire, w_last_fire;
  logic              skid_in_ready;
  logic [DATA_W:0]   skid_out;
  logic              unused_bits;

  assign start_edge = start_s1_q && !start_s2_q;

  // Burst length: bounded by MAX_BURST, the remaining beats and the room left in the 4 KB page.
  always_comb begin
    room_beats = 10'((13'(BOUNDARY_4K) - {1'b0, addr_q[11:0]}) >> 3);
    lim_a      = (beats_left_q < 29'(MAX_BURST)) ? beats_left_q : 29'(MAX_BURST);
    lim_b      = (29'(room_beats) < lim_a) ? 29'(room_beats) : lim_a;
    blen_c     = 9'(lim_b);
  end

  assign ofm_axi_ready = (state_q == ST_DATA) && (acc_q < blen_q) && skid_in_ready;
  assign up_fire       = ofm_bram_valid && ofm_axi_ready;
  assign b_fire        = m_axi_bvalid && m_axi_bready;
  assign w_last_fire   = m_axi_wvalid && m_axi_wready && m_axi_wlast;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    blen_d       = blen_q;
    acc_d        = acc_q;
    case (state_q)
      ST_IDLE: if (start_edge) begin
        addr_d       = ofm_base_addr;
        beats_left_d = ofm_transferbyte[31:3];
        state_d      = (ofm_transferbyte[31:3] == 29'd0) ? ST_DONE : ST_ADDR;
      end
      ST_ADDR: if (m_axi_awready) begin
        blen_d  = blen_c;
        acc_d   = 9'd0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (up_fire) acc_d = acc_q + 9'd1;
        if (w_last_fire) state_d = ST_RESP;
      end
      ST_RESP: if (b_fire) begin
        addr_d       = addr_q + ADDR_W'({blen_q, 3'b000});
        beats_left_d = beats_left_q - 29'(blen_q);
        state_d      = (beats_left_q == 29'(blen_q)) ? ST_DONE : ST_ADDR;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      addr_q       <= '0;
      beats_left_q <= '0;
      blen_q       <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      start_s1_q   <= ap_start;
      start_s2_q   <= start_s1_q;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      blen_q       <= blen_d;
      acc_q        <= acc_d;
    end
  end

  // The last-beat flag rides through the slice alongside the data.
  ofm_axi_skid #(.W(DATA_W + 1)) u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (up_fire),
    .in_ready_o  (skid_in_ready),
    .in_data_i   ({(acc_q == blen_q - 9'd1), ofm_bram_data}),
    .out_valid_o (m_axi_wvalid),
    .out_ready_i (m_axi_wready),
    .out_data_o  (skid_out)
  );

  assign m_axi_wdata   = skid_out[DATA_W-1:0];
  assign m_axi_wlast   = skid_out[DATA_W];
  assign m_axi_wstrb   = m_axi_wvalid ? '1 : '0;
  assign m_axi_awvalid = (state_q == ST_ADDR);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = m_axi_awvalid ? 8'(blen_c - 9'd1) : 8'd0;
  assign m_axi_awsize  = m_axi_awvalid ? SIZE_8B : 3'b000;
  assign m_axi_awburst = m_axi_awvalid ? BURST_INCR : 2'b00;
  assign m_axi_bready  = (state_q == ST_RESP);
  assign busy          = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_RESP);
  assign ap_done       = (state_q == ST_DONE);
  assign dbg_state     = state_q;

`ifdef OFM_WR_BRESP_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (state_q == ST_IDLE && start_edge) err_q <= 1'b0;
    else if (b_fire && m_axi_bresp != RESP_OKAY) err_q <= 1'b1;
  end
  assign ofm_wr_err  = err_q;
  assign unused_bits = ^ofm_transferbyte[2:0];
`else
  assign unused_bits = ^{ofm_transferbyte[2:0], m_axi_bresp};
`endif

endmodule

// File: tb/tb_ofm_axi_wr_master.sv
// Bench for ofm_axi_wr_master: random AXI/upstream stalls, AW and data scoreboards.
module tb_ofm_axi_wr_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ap_start = 1'b0;
  logic [31:0] ofm_base_addr = '0;
  logic [31:0] ofm_transferbyte = '0;
  logic        ofm_bram_valid = 1'b0;
  logic [63:0] ofm_bram_data = '0;
  logic        ofm_axi_ready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic        busy;
  logic        ap_done;
`ifdef OFM_WR_BRESP_CHECK_EN
  logic        ofm_wr_err;
`endif
  logic [2:0]  dbg_state;

  ofm_axi_wr_master dut (
    .clk(clk), .rst(rst), .ap_start(ap_start),
    .ofm_base_addr(ofm_base_addr), .ofm_transferbyte(ofm_transferbyte),
    .ofm_bram_valid(ofm_bram_valid), .ofm_bram_data(ofm_bram_data), .ofm_axi_ready(ofm_axi_ready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .busy(busy), .ap_done(ap_done),
`ifdef OFM_WR_BRESP_CHECK_EN
    .ofm_wr_err(ofm_wr_err),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [39:0] exp_aw_q[$];
  int  lens_q[$];
  int  beat_in_burst = 0;
  int  wlast_cnt = 0;
  int  b_issued = 0;
  int  err_burst = -1;
  int  aw_cnt = 0, w_cnt = 0, done_cnt = 0, awvalid_cycles = 0;
  bit  mon_en = 1'b0;
  int  aw_pct = 0, w_pct = 0, b_pct = 0, gap_pct = 0;
  bit  up_fire_f = 1'b0, b_fire_f = 1'b0;
  bit  aw_stall_prev = 1'b0, w_stall_prev = 1'b0;
  logic [31:0] prev_awaddr;
  logic [7:0]  prev_awlen;
  logic [63:0] prev_wdata;
  logic        prev_wlast;
  int  seq = 0;

  // ---------------- monitor (samples at negedge, handshakes land on the next posedge) ----------------
  always @(negedge clk) begin
    up_fire_f = ofm_bram_valid && ofm_axi_ready;
    b_fire_f  = m_axi_bvalid && m_axi_bready;
    if (!mon_en) begin
      exp_q.delete();
      lens_q.delete();
      beat_in_burst = 0;
      aw_stall_prev = 1'b0;
      w_stall_prev  = 1'b0;
    end else begin
      if (m_axi_awvalid) awvalid_cycles++;
      if (ap_done) done_cnt++;
      if (aw_stall_prev) begin
        n_checks++;
        if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== prev_awaddr || m_axi_awlen !== prev_awlen)
          $display("FAIL aw_stable: got v=%b addr=%h len=%0d want v=1 addr=%h len=%0d",
                   m_axi_awvalid, m_axi_awaddr, m_axi_awlen, prev_awaddr, prev_awlen);
        else n_pass++;
      end
      if (w_stall_prev) begin
        n_checks++;
        if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== prev_wdata || m_axi_wlast !== prev_wlast)
          $display("FAIL w_stable: got v=%b data=%h last=%b want v=1 data=%h last=%b",
                   m_axi_wvalid, m_axi_wdata, m_axi_wlast, prev_wdata, prev_wlast);
        else n_pass++;
      end
      aw_stall_prev = m_axi_awvalid && !m_axi_awready;
      prev_awaddr   = m_axi_awaddr;
      prev_awlen    = m_axi_awlen;
      w_stall_prev  = m_axi_wvalid && !m_axi_wready;
      prev_wdata    = m_axi_wdata;
      prev_wlast    = m_axi_wlast;

      if (up_fire_f) exp_q.push_back(ofm_bram_data);

      if (m_axi_awvalid && m_axi_awready) begin
        logic [39:0] e;
        int off;
        aw_cnt++;
        n_checks++;
        if (exp_aw_q.size() == 0) begin
          $display("FAIL aw_unexpected: got addr=%h len=%0d want no burst", m_axi_awaddr, m_axi_awlen);
        end else begin
          e = exp_aw_q.pop_front();
          if ({m_axi_awaddr, m_axi_awlen} !== e || m_axi_awsize !== 3'b011 || m_axi_awburst !== 2'b01)
            $display("FAIL aw_fields: got addr=%h len=%0d size=%b burst=%b want addr=%h len=%0d size=011 burst=01",
                     m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, e[39:8], e[7:0]);
          else n_pass++;
        end
        n_checks++;
        off = int'(m_axi_awaddr[11:0]);
        if (off + (int'(m_axi_awlen) + 1) * 8 > 4096)
          $display("FAIL aw_4k: got end offset %0d want <= 4096", off + (int'(m_axi_awlen) + 1) * 8);
        else n_pass++;
        lens_q.push_back(int'(m_axi_awlen));
      end

      if (m_axi_wvalid && m_axi_wready) begin
        logic [63:0] d;
        bit exp_last;
        w_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL w_unexpected: got data=%h want no beat", m_axi_wdata);
        end else begin
          d = exp_q.pop_front();
          if (m_axi_wdata !== d || m_axi_wstrb !== 8'hFF)
            $display("FAIL w_data: got data=%h strb=%h want data=%h strb=ff", m_axi_wdata, m_axi_wstrb, d);
          else n_pass++;
        end
        exp_last = (lens_q.size() > 0) && (beat_in_burst == lens_q[0]);
        n_checks++;
        if (m_axi_wlast !== exp_last)
          $display("FAIL w_last: got %b want %b (beat %0d)", m_axi_wlast, exp_last, beat_in_burst);
        else n_pass++;
        if (exp_last) begin
          void'(lens_q.pop_front());
          beat_in_burst = 0;
          wlast_cnt++;
        end else begin
          beat_in_burst++;
        end
      end
    end
  end

  // ---------------- AXI slave and upstream driver ----------------
  always @(posedge clk) begin
    #1;
    m_axi_awready = ($urandom_range(0, 99) >= aw_pct);
    m_axi_wready  = ($urandom_range(0, 99) >= w_pct);
    if (up_fire_f || !ofm_bram_valid) begin
      ofm_bram_valid = ($urandom_range(0, 99) >= gap_pct);
      ofm_bram_data  = {seq[31:0], $urandom};
      seq++;
    end
    if (b_fire_f) m_axi_bvalid = 1'b0;
    if (!m_axi_bvalid && (wlast_cnt > b_issued) && ($urandom_range(0, 99) >= b_pct)) begin
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = (b_issued == err_burst) ? 2'b10 : 2'b00;
      b_issued++;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int model_bursts(input logic [31:0] base, input logic [31:0] bytes);
    logic [31:0] a;
    int beats, n, room, bl;
    a = base;
    beats = int'(bytes >> 3);
    n = 0;
    while (beats > 0) begin
      room = (4096 - int'(a[11:0])) / 8;
      bl = (beats > 16) ? 16 : beats;
      if (room < bl) bl = room;
      exp_aw_q.push_back({a, 8'(bl - 1)});
      a = a + 32'(bl * 8);
      beats -= bl;
      n++;
    end
    return n;
  endfunction

  task automatic set_stalls(input int a, input int w, input int b, input int g);
    aw_pct = a; w_pct = w; b_pct = b; gap_pct = g;
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] bytes);
    @(posedge clk); #1;
    ofm_base_addr    = base;
    ofm_transferbyte = bytes;
    ap_start         = 1'b1;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    int c0;
    c0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done_cnt > c0) seen = 1'b1;
    end
  endtask

  task automatic end_xfer;
    @(posedge clk); #1;
    ap_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, ofm_axi_ready, busy, ap_done, m_axi_wlast} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000",
               {m_axi_awvalid, m_axi_wvalid, m_axi_bready, ofm_axi_ready, busy, ap_done, m_axi_wlast});
    else n_pass++;
    n_checks++;
    if ({m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wdata, m_axi_wstrb} !== '0)
      $display("FAIL reset_data: got awaddr=%h awlen=%h size=%b burst=%b wdata=%h strb=%h want all 0",
               m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wdata, m_axi_wstrb);
    else n_pass++;
`ifdef OFM_WR_BRESP_CHECK_EN
    n_checks++;
    if (ofm_wr_err !== 1'b0) $display("FAIL reset_err: got %b want 0", ofm_wr_err);
    else n_pass++;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_burst;
    bit seen;
    int aw0, w0, d0;
    aw0 = aw_cnt; w0 = w_cnt; d0 = done_cnt;
    set_stalls(0, 0, 0, 0);
    exp_aw_q.push_back({32'h1000_0000, 8'd9});
    start_xfer(32'h1000_0000, 32'd80);
    wait_done(500, seen);
    end_xfer();
    n_checks++;
    if (!seen) $display("FAIL single_done: got no ap_done want ap_done within 500 cycles");
    else n_pass++;
    n_checks++;
    if (aw_cnt - aw0 != 1 || w_cnt - w0 != 10 || done_cnt - d0 != 1)
      $display("FAIL single_counts: got bursts=%0d beats=%0d dones=%0d want 1/10/1",
               aw_cnt - aw0, w_cnt - w0, done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_multi_burst;
    bit seen;
    int aw0, w0;
    aw0 = aw_cnt; w0 = w_cnt;
    set_stalls(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) exp_aw_q.push_back({32'h1000_0000 + 32'(i * 32'h80), 8'd15});
    start_xfer(32'h1000_0000, 32'd1024);
    wait_done(2000, seen);
    end_xfer();
    n_checks++;
    if (!seen || aw_cnt - aw0 != 8 || w_cnt - w0 != 128 || exp_aw_q.size() != 0)
      $display("FAIL multi_counts: got done=%b bursts=%0d beats=%0d pending_aw=%0d want 1/8/128/0",
               seen, aw_cnt - aw0, w_cnt - w0, exp_aw_q.size());
    else n_pass++;
  endtask

  task automatic test_4k_split;
    bit seen;
    int aw0, w0;
    aw0 = aw_cnt; w0 = w_cnt;
    set_stalls(0, 0, 0, 0);
    exp_aw_q.push_back({32'h1000_0FE0, 8'd3});
    exp_aw_q.push_back({32'h1000_1000, 8'd7});
    start_xfer(32'h1000_0FE0, 32'd96);
    wait_done(1000, seen);
    end_xfer();
    n_checks++;
    if (!seen || aw_cnt - aw0 != 2 || w_cnt - w0 != 12)
      $display("FAIL split_counts: got done=%b bursts=%0d beats=%0d want 1/2/12", seen, aw_cnt - aw0, w_cnt - w0);
    else n_pass++;
  endtask

  task automatic test_random_stalls;
    for (int k = 0; k < 6; k++) begin
      bit seen;
      int aw0, w0, nb;
      logic [31:0] base, bytes;
      aw0 = aw_cnt; w0 = w_cnt;
      set_stalls($urandom_range(10, 90), $urandom_range(10, 90), $urandom_range(10, 90), $urandom_range(10, 90));
      base  = 32'h2000_0000 + 32'($urandom_range(0, 1023) << 3);
      bytes = 32'($urandom_range(1, 75) * 8) + 32'($urandom_range(0, 7));
      nb = model_bursts(base, bytes);
      start_xfer(base, bytes);
      wait_done(20000, seen);
      end_xfer();
      n_checks++;
      if (!seen || aw_cnt - aw0 != nb || w_cnt - w0 != int'(bytes >> 3) || exp_q.size() != 0)
        $display("FAIL random_xfer%0d: got done=%b bursts=%0d beats=%0d left=%0d want 1/%0d/%0d/0",
                 k, seen, aw_cnt - aw0, w_cnt - w0, exp_q.size(), nb, int'(bytes >> 3));
      else n_pass++;
    end
    set_stalls(0, 0, 0, 0);
  endtask

  task automatic test_zero_bytes;
    int d0, v0;
    d0 = done_cnt; v0 = awvalid_cycles;
    start_xfer(32'h1000_0000, 32'd7);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (ap_done !== 1'b0) $display("FAIL zero_early: got ap_done=%b want 0", ap_done);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ap_done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done: got ap_done=%b busy=%b want 1/0", ap_done, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ap_done !== 1'b0) $display("FAIL zero_pulse: got ap_done=%b want 0", ap_done);
    else n_pass++;
    end_xfer();
    n_checks++;
    if (awvalid_cycles != v0 || done_cnt - d0 != 1)
      $display("FAIL zero_traffic: got awvalid_cycles=%0d dones=%0d want 0/1", awvalid_cycles - v0, done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_start_while_busy;
    bit seen, was_busy;
    int aw0, w0, d0, nb;
    aw0 = aw_cnt; w0 = w_cnt; d0 = done_cnt;
    set_stalls(30, 30, 30, 30);
    nb = model_bursts(32'h5000_0F80, 32'd256);
    start_xfer(32'h5000_0F80, 32'd256);
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    ap_start = 1'b0;
    @(posedge clk); #1;
    ap_start = 1'b1;
    ofm_base_addr = 32'h6000_0000;
    ofm_transferbyte = 32'd4000;
    was_busy = busy;
    wait_done(5000, seen);
    repeat (20) @(negedge clk);
    n_checks++;
    if (!was_busy) $display("FAIL busy_restart_setup: got busy=0 want 1 at second edge");
    else n_pass++;
    n_checks++;
    if (!seen || busy !== 1'b0 || aw_cnt - aw0 != nb || w_cnt - w0 != 32 || done_cnt - d0 != 1)
      $display("FAIL busy_restart: got done=%b busy=%b bursts=%0d beats=%0d dones=%0d want 1/0/%0d/32/1",
               seen, busy, aw_cnt - aw0, w_cnt - w0, done_cnt - d0, nb);
    else n_pass++;
    end_xfer();
    set_stalls(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    bit seen, in_data;
    int w0, aw0, nb;
    set_stalls(0, 0, 0, 0);
    nb = model_bursts(32'h1000_0000, 32'd1024);
    w0 = w_cnt;
    start_xfer(32'h1000_0000, 32'd1024);
    in_data = 1'b0;
    for (int i = 0; i < 500 && !in_data; i++) begin
      @(negedge clk);
      if (dbg_state == 3'd2 && w_cnt - w0 >= 19) in_data = 1'b1;
    end
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b1;
    ap_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (!in_data || {m_axi_awvalid, m_axi_wvalid, m_axi_bready, ofm_axi_ready, busy, ap_done} !== 6'b0)
      $display("FAIL reset_mid: got in_data=%b ctrl=%b want 1/000000", in_data,
               {m_axi_awvalid, m_axi_wvalid, m_axi_bready, ofm_axi_ready, busy, ap_done});
    else n_pass++;
    exp_aw_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    mon_en = 1'b1;
    aw0 = aw_cnt; w0 = w_cnt;
    nb = model_bursts(32'h3000_0000, 32'd80);
    start_xfer(32'h3000_0000, 32'd80);
    wait_done(500, seen);
    end_xfer();
    n_checks++;
    if (!seen || aw_cnt - aw0 != nb || w_cnt - w0 != 10 || exp_q.size() != 0)
      $display("FAIL after_reset: got done=%b bursts=%0d beats=%0d left=%0d want 1/%0d/10/0",
               seen, aw_cnt - aw0, w_cnt - w0, exp_q.size(), nb);
    else n_pass++;
  endtask

`ifdef OFM_WR_BRESP_CHECK_EN
  task automatic test_bresp_err;
    bit seen;
    int w0, nb;
    set_stalls(0, 0, 0, 0);
    n_checks++;
    if (ofm_wr_err !== 1'b0) $display("FAIL err_before: got %b want 0", ofm_wr_err);
    else n_pass++;
    err_burst = b_issued + 1;
    w0 = w_cnt;
    nb = model_bursts(32'h4000_0000, 32'd256);
    start_xfer(32'h4000_0000, 32'd256);
    wait_done(1000, seen);
    end_xfer();
    err_burst = -1;
    n_checks++;
    if (!seen || ofm_wr_err !== 1'b1 || w_cnt - w0 != 32 || exp_aw_q.size() != 0)
      $display("FAIL err_set: got done=%b err=%b beats=%0d want 1/1/32 (%0d bursts)", seen, ofm_wr_err, w_cnt - w0, nb);
    else n_pass++;
    nb = model_bursts(32'h4000_1000, 32'd8);
    start_xfer(32'h4000_1000, 32'd8);
    wait_done(500, seen);
    end_xfer();
    n_checks++;
    if (!seen || ofm_wr_err !== 1'b0)
      $display("FAIL err_clear: got done=%b err=%b want 1/0 (%0d bursts)", seen, ofm_wr_err, nb);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_4k_split();
    test_zero_bytes();
    test_random_stalls();
    test_start_while_busy();
    test_reset_mid();
`ifdef OFM_WR_BRESP_CHECK_EN
    test_bresp_err();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running want finish before 90000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
